// File: rtl/serial_pkg.sv
// Shared definitions for the single-bit serial link (transmit and receive sides).
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } serial_state_t;

    // Total clock cycles one framed character occupies on the line.
    function automatic int frame_cycles(input int data_width,
                                        input int clks_per_bit,
                                        input int parity_en);
        return (2 + data_width + parity_en) * clks_per_bit;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Modulo-CLKS_PER_BIT counter that pulses tick on the last cycle of each bit time.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    assign tick = enable && (count == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit, data LSB first, optional even parity, stop bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic                  tx,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    serial_state_t         state, state_next;
    logic [DATA_WIDTH-1:0] shift, shift_next, shifted;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_next;
    logic                  parity_bit, parity_next;
    logic                  tx_reg, tx_next;
    logic                  timer_clear;
    logic                  tick;

    assign ready_out = (state == IDLE);
    assign busy      = (state != IDLE);
    assign tx        = tx_reg;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock (clock),
        .reset (reset),
        .clear (timer_clear),
        .enable(busy),
        .tick  (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
            tx_reg     <= 1'b1;
        end else begin
            state      <= state_next;
            shift      <= shift_next;
            bit_cnt    <= bit_cnt_next;
            parity_bit <= parity_next;
            tx_reg     <= tx_next;
        end
    end

    // tx_next is the line level for the state being entered, so tx changes on the same edge as the state.
    always_comb begin
        state_next   = state;
        shift_next   = shift;
        shifted      = shift >> 1;
        bit_cnt_next = bit_cnt;
        parity_next  = parity_bit;
        tx_next      = tx_reg;
        timer_clear  = 1'b0;

        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (valid_in) begin
                    state_next  = START;
                    shift_next  = data_in;
                    parity_next = ^data_in;
                    tx_next     = 1'b0;
                    timer_clear = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                    tx_next      = shift[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next   = shifted;
                    bit_cnt_next = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            state_next = PARITY;
                            tx_next    = parity_bit;
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        tx_next = shifted[0];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// Randomized self-checking bench for serial_tx across three parameter sets sharing one clock and reset.
module tb_serial_tx;

    logic            clock;
    logic            reset;
    logic [2:0][7:0] dataIn;
    logic [2:0]      validIn;
    logic [2:0]      readyOut;
    logic [2:0]      txLine;
    logic [2:0]      busyOut;

    int checks = 0;
    int errors = 0;
    int cpbCfg[3] = '{4, 4, 1};
    int parCfg[3] = '{0, 1, 0};

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u0 (
        .clock(clock), .reset(reset), .data_in(dataIn[0]), .valid_in(validIn[0]),
        .ready_out(readyOut[0]), .tx(txLine[0]), .busy(busyOut[0]));

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u1 (
        .clock(clock), .reset(reset), .data_in(dataIn[1]), .valid_in(validIn[1]),
        .ready_out(readyOut[1]), .tx(txLine[1]), .busy(busyOut[1]));

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u2 (
        .clock(clock), .reset(reset), .data_in(dataIn[2]), .valid_in(validIn[2]),
        .ready_out(readyOut[2]), .tx(txLine[2]), .busy(busyOut[2]));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference line level for bit slot k of a frame: start, 8 data bits LSB first, optional parity, stop.
    function automatic logic expBit(input logic [7:0] word, input int par, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return word[k-1];
        if (par != 0 && k == 9) return ($countones(word) % 2) == 1;
        return 1'b1;
    endfunction

    // Called at a negedge with the instance idle; returns at the negedge of the first idle cycle after the frame.
    task automatic applyStimulus(input int idx, input logic [7:0] word, input bit keepHigh, input logic [7:0] nextWord);
        int cpb;
        int frameLen;
        cpb      = cpbCfg[idx];
        frameLen = (10 + parCfg[idx]) * cpb;
        dataIn[idx]  = word;
        validIn[idx] = 1'b1;
        checkOutput($sformatf("ready_before_u%0d", idx), 32'(readyOut[idx]), 32'd1);
        @(posedge clock);
        for (int c = 0; c < frameLen; c++) begin
            @(negedge clock);
            checkOutput($sformatf("tx_u%0d_w%02h_c%0d", idx, word, c), 32'(txLine[idx]),
                        32'(expBit(word, parCfg[idx], c / cpb)));
            checkOutput($sformatf("busy_ready_u%0d_c%0d", idx, c), 32'({busyOut[idx], readyOut[idx]}), 32'b10);
            if (c == 0) validIn[idx] = keepHigh;
            if (keepHigh && c == frameLen - 1) dataIn[idx] = nextWord;
            else dataIn[idx] = 8'($urandom);
        end
        @(negedge clock);
        checkOutput($sformatf("idle_after_u%0d", idx), 32'({txLine[idx], busyOut[idx], readyOut[idx]}), 32'b101);
    endtask

    // Starts a frame, lets it run to cycle cyclesIn-1, then asserts reset while the clock is low.
    task automatic abortFrame(input int idx, input logic [7:0] word, input int cyclesIn);
        dataIn[idx]  = word;
        validIn[idx] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        validIn[idx] = 1'b0;
        repeat (cyclesIn - 1) @(negedge clock);
        checkOutput($sformatf("abort_pre_tx_u%0d", idx), 32'(txLine[idx]),
                    32'(expBit(word, parCfg[idx], (cyclesIn - 1) / cpbCfg[idx])));
        #2 reset = 1'b1;
        #1 checkOutput($sformatf("abort_async_u%0d", idx),
                       32'({txLine[idx], busyOut[idx], readyOut[idx]}), 32'b101);
        @(posedge clock);
        #1 checkOutput($sformatf("abort_held_u%0d", idx),
                       32'({txLine[idx], busyOut[idx], readyOut[idx]}), 32'b101);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput($sformatf("abort_release_u%0d", idx),
                    32'({txLine[idx], busyOut[idx], readyOut[idx]}), 32'b101);
    endtask

    initial begin
        logic [7:0] word;
        logic [7:0] nextWord;
        int         idx;

        reset   = 1'b1;
        validIn = '0;
        dataIn  = '0;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("reset_u%0d", i), 32'({txLine[i], busyOut[i], readyOut[i]}), 32'b101);
        reset = 1'b0;

        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            for (int i = 0; i < 3; i++)
                checkOutput($sformatf("idle_u%0d_c%0d", i, c), 32'({txLine[i], busyOut[i], readyOut[i]}), 32'b101);
        end

        applyStimulus(0, 8'hA5, 1'b0, 8'h00);
        applyStimulus(1, 8'h07, 1'b0, 8'h00);
        applyStimulus(1, 8'h03, 1'b0, 8'h00);
        applyStimulus(0, 8'h55, 1'b1, 8'hAA);
        applyStimulus(0, 8'hAA, 1'b0, 8'h00);
        abortFrame(0, 8'hFF, 18);
        applyStimulus(0, 8'h01, 1'b0, 8'h00);
        abortFrame(1, 8'h00, 3);
        applyStimulus(1, 8'hC4, 1'b0, 8'h00);
        applyStimulus(2, 8'h80, 1'b0, 8'h00);
        applyStimulus(2, 8'h3C, 1'b1, 8'hE1);
        applyStimulus(2, 8'hE1, 1'b0, 8'h00);

        for (int n = 0; n < 30; n++) begin
            idx      = $urandom_range(0, 2);
            word     = 8'($urandom);
            nextWord = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus(idx, word, 1'b1, nextWord);
                applyStimulus(idx, nextWord, 1'b0, 8'h00);
            end else begin
                applyStimulus(idx, word, 1'b0, 8'h00);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
